ysram_port_arbiter: RTL and testbench

- Shares the y_sram read port 1 and its single write port between two requesters: requester 0 (compute/accumulate path) and requester 1 (rank-update path).
- Independent round-robin arbitration per port.
- Resolves read/write address collisions in the same cycle.
- Returns read data with a per-requester valid strobe.
- Sits between the two engines and the y_sram macro. It replaces direct engine-to-SRAM wiring of ReadAddress1/WE/WriteAddress/WriteBus.

---
 rtl/ysram_port_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_ysram_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysram_port_arbiter.sv
// -----------------------------------------------------------------------------
// ysram_port_arbiter
//
// Shares y_sram read port 1 and the single y_sram write port between two
// requesters: requester 0 (compute/accumulate path) and requester 1
// (rank-update path). Each port has its own round-robin pointer. Grants are
// combinational (0-cycle latency); read data returns one cycle after the grant
// edge with a per-requester valid strobe.
//
// Read/write collision (read winner and write winner on the same address in
// the same cycle):
//   default build          : the read is stalled for one cycle and re-arbitrated,
//                            so it returns the freshly written word.
//   YSRAM_ARB_FWD_EN build : the read is granted anyway and the write data is
//                            forwarded through a DW-bit register on the next cycle.
//
// Optional feature macro: YSRAM_ARB_FWD_EN
//
// Ports
//   clock          in   single clock, rising edge
//   reset          in   synchronous active-low reset
//   rd_req[1:0]    in   read request per requester
//   rd_addr0/1     in   read address per requester
//   rd_gnt[1:0]    out  read grant (combinational, one-hot or zero)
//   rd_valid[1:0]  out  read data valid per requester (registered)
//   rd_data        out  shared read data, qualified by rd_valid
//   wr_req[1:0]    in   write request per requester
//   wr_addr0/1     in   write address per requester
//   wr_data0/1     in   write data per requester
//   wr_gnt[1:0]    out  write grant (combinational, one-hot or zero)
//   ReadAddress1   out  y_sram read port 1 address
//   ReadBus1       in   y_sram read port 1 data (one cycle after address)
//   WE             out  y_sram write enable
//   WriteAddress   out  y_sram write address
//   WriteBus       out  y_sram write data
// -----------------------------------------------------------------------------
module ysram_port_arbiter #(
   parameter int unsigned AW = 11,
   parameter int unsigned DW = 256
) (
   input  logic          clock,
   input  logic          reset,
   // read requesters
   input  logic [1:0]    rd_req,
   input  logic [AW-1:0] rd_addr0,
   input  logic [AW-1:0] rd_addr1,
   output logic [1:0]    rd_gnt,
   output logic [1:0]    rd_valid,
   output logic [DW-1:0] rd_data,
   // write requesters
   input  logic [1:0]    wr_req,
   input  logic [AW-1:0] wr_addr0,
   input  logic [AW-1:0] wr_addr1,
   input  logic [DW-1:0] wr_data0,
   input  logic [DW-1:0] wr_data1,
   output logic [1:0]    wr_gnt,
   // y_sram side
   output logic [AW-1:0] ReadAddress1,
   input  logic [DW-1:0] ReadBus1,
   output logic          WE,
   output logic [AW-1:0] WriteAddress,
   output logic [DW-1:0] WriteBus
);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic          rd_ptr;        // read-port priority pointer
   logic          wr_ptr;        // write-port priority pointer
   logic [AW-1:0] last_rd_addr;  // address held on ReadAddress1 when idle
   logic [1:0]    rd_tag;        // winner of the previous cycle's read

`ifdef YSRAM_ARB_FWD_EN
   logic          fwd_flag;      // next rd_data comes from fwd_data
   logic [DW-1:0] fwd_data;      // write data captured on a collision
`endif

   // ---------------------------------------------------------------------------
   // Combinational arbitration
   // ---------------------------------------------------------------------------
   logic          rd_any;
   logic          rd_id;
   logic [AW-1:0] rd_sel_addr;
   logic          rd_cand;
   logic          rd_win;

   logic          wr_any;
   logic          wr_id;
   logic [AW-1:0] wr_sel_addr;
   logic [DW-1:0] wr_sel_data;
   logic          wr_win;

   logic          collision;

   // Read-port winner selection: single requester wins outright, pointer breaks ties
   always_comb begin
      rd_any      = |rd_req;
      rd_id       = (rd_req == 2'b11) ? rd_ptr : rd_req[1];
      rd_sel_addr = rd_id ? rd_addr1 : rd_addr0;
   end

   // Write-port winner selection
   always_comb begin
      wr_any      = |wr_req;
      wr_id       = (wr_req == 2'b11) ? wr_ptr : wr_req[1];
      wr_sel_addr = wr_id ? wr_addr1 : wr_addr0;
      wr_sel_data = wr_id ? wr_data1 : wr_data0;
   end

   // Grant qualification; reset low suppresses every grant
   always_comb begin
      wr_win    = reset & wr_any;
      rd_cand   = reset & rd_any;
      collision = rd_cand & wr_win & (rd_sel_addr == wr_sel_addr);
`ifdef YSRAM_ARB_FWD_EN
      rd_win    = rd_cand;
`else
      // Stall the read so it re-arbitrates after the write has landed
      rd_win    = rd_cand & ~collision;
`endif
   end

   // Grant vectors and SRAM-facing drive
   always_comb begin
      rd_gnt       = 2'b00;
      wr_gnt       = 2'b00;
      ReadAddress1 = last_rd_addr;
      WE           = 1'b0;
      WriteAddress = '0;
      WriteBus     = '0;

      if (rd_win) begin
         rd_gnt       = rd_id ? 2'b10 : 2'b01;
         ReadAddress1 = rd_sel_addr;
      end

      if (wr_win) begin
         wr_gnt       = wr_id ? 2'b10 : 2'b01;
         WE           = 1'b1;
         WriteAddress = wr_sel_addr;
         WriteBus     = wr_sel_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Sequential state
   // ---------------------------------------------------------------------------

   // Round-robin pointers and idle read address
   always_ff @(posedge clock) begin
      if (!reset) begin
         rd_ptr       <= 1'b0;
         wr_ptr       <= 1'b0;
         last_rd_addr <= '0;
      end else begin
         if (rd_win) begin
            rd_ptr       <= ~rd_id;
            last_rd_addr <= rd_sel_addr;
         end
         if (wr_win) begin
            wr_ptr <= ~wr_id;
         end
      end
   end

   // Read-return tag: one-hot winner of the previous cycle, never 2'b11
   always_ff @(posedge clock) begin
      if (!reset) begin
         rd_tag <= 2'b00;
      end else begin
         rd_tag <= rd_gnt;
      end
   end

`ifdef YSRAM_ARB_FWD_EN
   // Forward register: holds the colliding write word for the next-cycle return
   always_ff @(posedge clock) begin
      if (!reset) begin
         fwd_flag <= 1'b0;
         fwd_data <= '0;
      end else begin
         fwd_flag <= collision;
         if (collision) begin
            fwd_data <= wr_sel_data;
         end
      end
   end
`endif

   // Read return
   always_comb begin
      rd_valid = rd_tag;
`ifdef YSRAM_ARB_FWD_EN
      rd_data  = fwd_flag ? fwd_data : ReadBus1;
`else
      rd_data  = ReadBus1;
`endif
   end

endmodule

// File: tb/tb_ysram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ysram_port_arbiter
//
// Drives ysram_port_arbiter against a behavioural y_sram (1-cycle read,
// write at the clock edge). A bench-side reference model predicts every
// cycle's grants and SRAM drive; expected read returns are queued at the
// grant edge and popped when the return cycle is sampled.
// Build with +define+YSRAM_ARB_FWD_EN to exercise the forwarding variant.
// -----------------------------------------------------------------------------
module tb_ysram_port_arbiter;

   localparam int unsigned AW    = 11;
   localparam int unsigned DW    = 256;
   localparam int unsigned DEPTH = 2048;

   logic          clock;
   logic          reset;
   logic [1:0]    rd_req;
   logic [AW-1:0] rd_addr0;
   logic [AW-1:0] rd_addr1;
   logic [1:0]    rd_gnt;
   logic [1:0]    rd_valid;
   logic [DW-1:0] rd_data;
   logic [1:0]    wr_req;
   logic [AW-1:0] wr_addr0;
   logic [AW-1:0] wr_addr1;
   logic [DW-1:0] wr_data0;
   logic [DW-1:0] wr_data1;
   logic [1:0]    wr_gnt;
   logic [AW-1:0] ReadAddress1;
   logic [DW-1:0] ReadBus1;
   logic          WE;
   logic [AW-1:0] WriteAddress;
   logic [DW-1:0] WriteBus;

   ysram_port_arbiter #(.AW(AW), .DW(DW)) dut (
      .clock        (clock),
      .reset        (reset),
      .rd_req       (rd_req),
      .rd_addr0     (rd_addr0),
      .rd_addr1     (rd_addr1),
      .rd_gnt       (rd_gnt),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .wr_req       (wr_req),
      .wr_addr0     (wr_addr0),
      .wr_addr1     (wr_addr1),
      .wr_data0     (wr_data0),
      .wr_data1     (wr_data1),
      .wr_gnt       (wr_gnt),
      .ReadAddress1 (ReadAddress1),
      .ReadBus1     (ReadBus1),
      .WE           (WE),
      .WriteAddress (WriteAddress),
      .WriteBus     (WriteBus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Preload pattern of every word that has not been written yet
   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      return {8{32'hC0DE_0000 | 32'(a)}};
   endfunction

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom();
      return w;
   endfunction

   // Behavioural y_sram: registered read, write committed at the edge
   logic [DW-1:0] sram    [DEPTH];
   bit            sram_wr [DEPTH];
   always @(posedge clock) begin
      ReadBus1 <= sram_wr[ReadAddress1] ? sram[ReadAddress1] : init_val(ReadAddress1);
      if (WE) begin
         sram[WriteAddress]    <= WriteBus;
         sram_wr[WriteAddress] <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model and scoreboard
   // ---------------------------------------------------------------------------
   typedef struct {
      logic          id;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] ref_mem [DEPTH];
   logic          m_rptr, m_wptr;
   logic [AW-1:0] m_last;
   logic          m_rany, m_wany, m_rid, m_wid, m_coll, m_rgo;
   logic [AW-1:0] m_raddr, m_waddr;
   logic [DW-1:0] m_wdata, m_rexp;
   logic [1:0]    m_rg, m_wg;

   // One clock cycle: sample at the falling edge, optionally assert reset,
   // then advance the model at the rising edge.
   task automatic step(input bit rst_after);
      exp_t e;
      @(negedge clock);

      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("rd_valid", DW'(rd_valid), DW'(e.id ? 2'b10 : 2'b01));
         check("rd_data", rd_data, e.data);
      end else begin
         check("rd_valid_idle", DW'(rd_valid), DW'(2'b00));
      end

      m_rany  = reset && (rd_req != 2'b00);
      m_rid   = (rd_req == 2'b11) ? m_rptr : rd_req[1];
      m_raddr = m_rid ? rd_addr1 : rd_addr0;
      m_wany  = reset && (wr_req != 2'b00);
      m_wid   = (wr_req == 2'b11) ? m_wptr : wr_req[1];
      m_waddr = m_wid ? wr_addr1 : wr_addr0;
      m_wdata = m_wid ? wr_data1 : wr_data0;
      m_coll  = m_rany && m_wany && (m_raddr == m_waddr);
`ifdef YSRAM_ARB_FWD_EN
      m_rgo   = m_rany;
`else
      m_rgo   = m_rany && !m_coll;
`endif
      m_rexp  = m_coll ? m_wdata : ref_mem[m_raddr];
      m_rg    = m_rgo  ? (m_rid ? 2'b10 : 2'b01) : 2'b00;
      m_wg    = m_wany ? (m_wid ? 2'b10 : 2'b01) : 2'b00;

      check("rd_gnt", DW'(rd_gnt), DW'(m_rg));
      check("wr_gnt", DW'(wr_gnt), DW'(m_wg));
      check("WE", DW'(WE), DW'(m_wany));
      check("WriteAddress", DW'(WriteAddress), DW'(m_wany ? m_waddr : '0));
      check("WriteBus", WriteBus, m_wany ? m_wdata : '0);
      check("ReadAddress1", DW'(ReadAddress1), DW'(m_rgo ? m_raddr : m_last));

      if (rst_after) reset = 1'b0;
      @(posedge clock);

      if (!reset) begin
         m_rptr = 1'b0;
         m_wptr = 1'b0;
         m_last = '0;
         sb.delete();
      end else begin
         if (m_rgo) begin
            e.id   = m_rid;
            e.data = m_rexp;
            sb.push_back(e);
            m_rptr = ~m_rid;
            m_last = m_raddr;
         end
         if (m_wany) begin
            m_wptr           = ~m_wid;
            ref_mem[m_waddr] = m_wdata;
         end
      end
      #1;
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      logic [AW-1:0] a;

      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(AW'(i));
      m_rptr = 1'b0;
      m_wptr = 1'b0;
      m_last = '0;
      m_rg   = 2'b00;
      m_wg   = 2'b00;

      // Reset held with everything requesting
      reset    = 1'b0;
      rd_req   = 2'b11;
      wr_req   = 2'b11;
      rd_addr0 = 11'h010;
      rd_addr1 = 11'h020;
      wr_addr0 = 11'h005;
      wr_addr1 = 11'h006;
      wr_data0 = {8{32'hA5A5_A5A5}};
      wr_data1 = {8{32'h5A5A_5A5A}};
      @(posedge clock);
      #1;
      step(1'b0);
      step(1'b0);

      // Release: r0 first on both ports, then read/write contention alternates
      reset = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (c == 2) wr_req = 2'b00;
         step(1'b0);
      end
      rd_req = 2'b00;
      step(1'b0);

      // Readback of the two contended writes
      rd_req   = 2'b01;
      rd_addr0 = 11'h005;
      step(1'b0);
      rd_addr0 = 11'h006;
      step(1'b0);
      rd_req = 2'b00;
      step(1'b0);

      // Collision: r0 reads 0x100 while r1 writes 0x100
      rd_req   = 2'b01;
      rd_addr0 = 11'h100;
      wr_req   = 2'b10;
      wr_addr1 = 11'h100;
      wr_data1 = {8{32'h1234_5678}};
      step(1'b0);
      wr_req = 2'b00;
      for (int k = 0; k < 4 && !m_rg[0]; k++) step(1'b0);
      if (!m_rg[0]) check("coll_regrant_timeout", DW'(rd_gnt), DW'(2'b01));
      rd_req = 2'b00;
      step(1'b0);
      step(1'b0);

      // Reset mid-read: r1 granted, reset sampled at the grant edge
      rd_req   = 2'b10;
      rd_addr1 = 11'h020;
      step(1'b1);
      rd_req = 2'b00;
      step(1'b0);
      reset  = 1'b1;
      rd_req = 2'b11;
      wr_req = 2'b11;
      step(1'b0);
      rd_req = 2'b00;
      wr_req = 2'b00;
      step(1'b0);

      // Random traffic on a small address window to provoke collisions;
      // a requester holds its request until the model says it was granted
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (!rd_req[i] || m_rg[i]) begin
               rd_req[i] = 1'($urandom_range(0, 1));
               a = AW'($urandom_range(0, 7));
               if (i == 0) rd_addr0 = a;
               else        rd_addr1 = a;
            end
            if (!wr_req[i] || m_wg[i]) begin
               wr_req[i] = 1'($urandom_range(0, 1));
               a = AW'($urandom_range(0, 7));
               if (i == 0) begin
                  wr_addr0 = a;
                  wr_data0 = rand_word();
               end else begin
                  wr_addr1 = a;
                  wr_data1 = rand_word();
               end
            end
         end
         step(1'b0);
      end
      rd_req = 2'b00;
      wr_req = 2'b00;
      step(1'b0);
      step(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
